fp_product_accumulator: RTL and testbench

//  Downstream consumer of the registered FP32 multiplier: sums a stream of
//  FP32 products into one FP32 result (dot-product reduction). A multi-cycle
//  FSM performs alignment, add/subtract and normalisation per accepted term.

---
 rtl/fp_product_accumulator_if.sv | 22 ++
 rtl/fp_product_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_fp_product_accumulator.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_product_accumulator_if.sv
// Term-in / sum-out handshake bundle for the FP32 product accumulator.
interface fp_product_accumulator_if #(parameter int unsigned CNT_W = 16) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [CNT_W-1:0] out_count;
   logic             busy;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, busy
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, busy
   );
endinterface

// File: rtl/fp_product_accumulator.sv
// Sums a stream of simplified FP32 terms (no NaN/Inf/denormals, truncating)
// into one FP32 result per sequence, one term at a time via a multi-cycle FSM.
module fp_product_accumulator #(
   parameter int unsigned CNT_W = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   fp_product_accumulator_if.slave bus
);
   localparam int unsigned MAG_W = 25;

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        term_q, term_d;
   logic               last_q, last_d;
   logic [MAG_W-1:0]   mag_q, mag_d;
   logic [MAG_W-1:0]   sml_q, sml_d;
   logic [7:0]         exp_q, exp_d;
   logic               sign_q, sign_d;
   logic               sub_q, sub_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_data_q, out_data_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               busy_q, busy_d;

   logic               in_ready;
   logic               leave;
   logic [31:0]        other, big, sml;
   logic [7:0]         diff;

   assign in_ready      = (state_q == S_IDLE) && !out_valid_q;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign bus.busy      = busy_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      term_d      = term_q;
      last_d      = last_q;
      mag_d       = mag_q;
      sml_d       = sml_q;
      exp_d       = exp_q;
      sign_d      = sign_q;
      sub_d       = sub_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      leave       = 1'b0;
      other       = 32'h0;
      big         = acc_q;
      sml         = term_q;
      diff        = 8'h0;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready) begin
               term_d  = bus.in_data;
               last_d  = bus.in_last;
               count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
               // A zero operand skips alignment: the sum is simply the other one
               if (acc_q[30:23] == 8'h0 || bus.in_data[30:23] == 8'h0) begin
                  other = (acc_q[30:23] == 8'h0) ? bus.in_data : acc_q;
                  if (other[30:23] == 8'h0) begin
                     mag_d  = '0;
                     exp_d  = 8'h0;
                     sign_d = 1'b0;
                  end else begin
                     mag_d  = {2'b01, other[22:0]};
                     exp_d  = other[30:23];
                     sign_d = other[31];
                  end
                  state_d = S_NORM;
               end else begin
                  state_d = S_ALIGN;
               end
            end
         end
         S_ALIGN: begin
            if (term_q[30:0] > acc_q[30:0]) begin
               big = term_q;
               sml = acc_q;
            end
            diff   = big[30:23] - sml[30:23];
            mag_d  = {2'b01, big[22:0]};
            sml_d  = (diff >= 8'd25) ? '0 : ({2'b01, sml[22:0]} >> diff);
            exp_d  = big[30:23];
            sign_d = big[31];
            sub_d  = big[31] ^ sml[31];
            state_d = S_ADD;
         end
         S_ADD: begin
            mag_d   = sub_q ? (mag_q - sml_q) : (mag_q + sml_q);
            state_d = S_NORM;
         end
         S_NORM: begin
            if (mag_q[24]) begin
               if (exp_q == 8'd254) begin
                  acc_d = {sign_q, 8'hFF, 23'h0};
                  leave = 1'b1;
               end else begin
                  mag_d = mag_q >> 1;
                  exp_d = exp_q + 8'd1;
               end
            end else if (mag_q[23]) begin
               acc_d = {sign_q, exp_q, mag_q[22:0]};
               leave = 1'b1;
            end else if (mag_q == '0 || exp_q == 8'd1) begin
               acc_d = 32'h0;
               leave = 1'b1;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 8'd1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = 32'h0;
               count_d     = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (leave) begin
         if (last_q) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_data_d  = acc_d;
            out_count_d = count_q;
         end else begin
            state_d = S_IDLE;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= 32'h0;
         count_q     <= '0;
         term_q      <= 32'h0;
         last_q      <= 1'b0;
         mag_q       <= '0;
         sml_q       <= '0;
         exp_q       <= 8'h0;
         sign_q      <= 1'b0;
         sub_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0;
         out_count_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         term_q      <= term_d;
         last_q      <= last_d;
         mag_q       <= mag_d;
         sml_q       <= sml_d;
         exp_q       <= exp_d;
         sign_q      <= sign_d;
         sub_q       <= sub_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         busy_q      <= busy_d;
      end
   end
endmodule

// File: tb/tb_fp_product_accumulator.sv
// Bench for fp_product_accumulator: directed cases plus random sequences
// checked against an integer-arithmetic model of truncating FP32 addition.
module tb_fp_product_accumulator;
   localparam int unsigned CNT_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fp_product_accumulator_if #(.CNT_W(CNT_W)) bus ();

   fp_product_accumulator #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: exact integer sum on the larger operand's grid, then truncate
   function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] bg, sm;
      int          eb, es, d, p, e;
      longint      mb, ms, v, mant;
      if (a[30:23] == 8'h0) return (b[30:23] == 8'h0) ? 32'h0 : b;
      if (b[30:23] == 8'h0) return a;
      if (a[30:0] >= b[30:0]) begin bg = a; sm = b; end
      else begin bg = b; sm = a; end
      eb = int'(bg[30:23]);
      es = int'(sm[30:23]);
      d  = eb - es;
      mb = longint'({1'b1, bg[22:0]});
      ms = (d >= 25) ? 64'sd0 : (longint'({1'b1, sm[22:0]}) >>> d);
      v  = (bg[31] == sm[31]) ? mb + ms : mb - ms;
      if (v == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 25; i++) if (v[i]) p = i;
      e = eb + p - 23;
      if (e >= 255) return {bg[31], 8'hFF, 23'h0};
      if (e < 1) return 32'h0;
      mant = (p >= 23) ? (v >>> (p - 23)) : (v <<< (23 - p));
      return {bg[31], 8'(e), 23'(mant)};
   endfunction

   task automatic send_term(input logic [31:0] d, input logic l);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (!bus.in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic get_result(output logic [31:0] d, output logic [CNT_W-1:0] c);
      int n = 0;
      bus.out_ready = 1'b1;
      while (!bus.out_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL result_timeout: out_valid stayed %b, required 1", bus.out_valid);
      end
      d = bus.out_data;
      c = bus.out_count;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run_seq(input logic [31:0] terms[$], output logic [31:0] d,
                          output logic [CNT_W-1:0] c);
      for (int i = 0; i < terms.size(); i++)
         send_term(terms[i], (i == terms.size() - 1));
      get_result(d, c);
   endtask

   task automatic test_reset;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_count !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b data=%h count=%0d, required 0/0/0",
                  bus.out_valid, bus.out_data, bus.out_count);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b, required 0", bus.busy);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
      end
   endtask

   task automatic test_directed;
      logic [31:0]      q[$];
      logic [31:0]      exp_d[4];
      logic [31:0]      d;
      logic [CNT_W-1:0] c;
      exp_d = '{32'h40400000, 32'h3E800000, 32'h00000000, 32'h4E800000};
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       q = '{32'h3F800000, 32'h40000000};
            1:       q = '{32'h3F800000, 32'hBF400000};
            2:       q = '{32'h3F800000, 32'hBF800000};
            default: q = '{32'h4E800000, 32'h3F800000};
         endcase
         run_seq(q, d, c);
         checks++;
         if (d !== exp_d[k]) begin
            errors++;
            $display("FAIL directed_%0d_data: got %h, required %h", k, d, exp_d[k]);
         end
         checks++;
         if (c !== CNT_W'(2)) begin
            errors++;
            $display("FAIL directed_%0d_count: got %0d, required 2", k, c);
         end
      end
   endtask

   task automatic test_hold;
      int n = 0;
      bus.out_ready = 1'b0;
      send_term(32'h80000000, 1'b1);
      while (!bus.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0 || bus.out_count !== CNT_W'(1)
          || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL hold_first: valid=%b data=%h count=%0d busy=%b, required 1/0/1/1",
                  bus.out_valid, bus.out_data, bus.out_count, bus.busy);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0 || bus.out_count !== CNT_W'(1)
             || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable_%0d: valid=%b data=%h count=%0d in_ready=%b, required 1/0/1/0",
                     i, bus.out_valid, bus.out_data, bus.out_count, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: valid=%b in_ready=%b busy=%b, required 0/1/0",
                  bus.out_valid, bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0]      q[$];
      logic [31:0]      d;
      logic [CNT_W-1:0] c;
      send_term(32'h3F800000, 1'b0);
      // wait for the bypass term to pack, then accept a term needing alignment
      send_term(32'h40000000, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_count !== '0
          || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_outputs: valid=%b data=%h count=%0d busy=%b in_ready=%b, required 0/0/0/0/1",
                  bus.out_valid, bus.out_data, bus.out_count, bus.busy, bus.in_ready);
      end
      rst_n = 1'b1;
      q = '{32'h40000000};
      run_seq(q, d, c);
      checks++;
      if (d !== 32'h40000000 || c !== CNT_W'(1)) begin
         errors++;
         $display("FAIL midreset_after: data=%h count=%0d, required 40000000/1", d, c);
      end
   endtask

   task automatic test_random;
      logic [31:0]      q[$];
      logic [31:0]      acc, t, d;
      logic [CNT_W-1:0] c;
      int               n, sel;
      for (int s = 0; s < 40; s++) begin
         n   = int'($urandom_range(1, 6));
         acc = 32'h0;
         q.delete();
         for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 7));
            t   = $urandom;
            if (sel == 0)      t[30:23] = 8'h0;
            else if (sel == 1) t[30:23] = 8'($urandom_range(1, 6));
            else if (sel == 2 && acc != 32'h0) t = {~acc[31], acc[30:0]};
            else               t[30:23] = 8'($urandom_range(110, 145));
            q.push_back(t);
            acc = model_add(acc, t);
         end
         run_seq(q, d, c);
         checks++;
         if (d !== acc) begin
            errors++;
            $display("FAIL random_%0d_data: got %h, required %h", s, d, acc);
         end
         checks++;
         if (c !== CNT_W'(n)) begin
            errors++;
            $display("FAIL random_%0d_count: got %0d, required %0d", s, c, n);
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
